// File: rtl/memory_responder.sv
// memory_responder: single-port word-addressed SRAM responder on the shared
// memory bus. It serves one request at a time and answers each one with a
// single-cycle memory_ready pulse.
//
// Optional feature macro: MEMORY_LATENCY_EN
//   defined   - a WAIT state and a 4-bit counter insert LATENCY wait states.
//   undefined - ready is always returned one cycle after acceptance, and
//               LATENCY is ignored.
//
// Handshake: a request is accepted on any rising edge where memory_valid=1
// and the FSM is in IDLE or RESP. The initiator holds the same request until
// it sees memory_ready. Valid seen during WAIT is the request already pending.
// Valid seen during the RESP cycle is a new request, which allows
// back-to-back transfers. memory_rdata is non-zero only while memory_ready=1.
module memory_responder #(
    parameter int          DEPTH   = 16384,
    parameter logic [31:0] BASE    = 32'h0,
    parameter int          LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic [1:0]  o_state
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(BASE) + 33'(4 * DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_ready;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept_ok;
    logic          w_in_range;
    logic [AW-1:0] w_in_idx;
    logic          w_in_rd_ok;
    logic          w_wr_en;
    logic [AW-1:0] w_rd_idx;
    logic [31:0]   w_mem_rd;
    logic          w_unused;

    // A byte address is in range when BASE <= addr < BASE + 4*DEPTH.
    function automatic logic f_in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIMIT);
    endfunction

    // Word index relative to BASE. The byte offset bits fall away in the shift.
    function automatic logic [AW-1:0] f_idx(input logic [31:0] a);
        return AW'((a - BASE) >> 2);
    endfunction

    // A fetch is always a read. A data access with zero strobes is also a read.
    function automatic logic f_is_read(input logic ins, input logic [3:0] st);
        return ins || (st == 4'b0000);
    endfunction

`ifdef MEMORY_LATENCY_EN
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_instr;
    logic [3:0]  r_wstrb;
    logic        w_q_rd_ok;
`endif

    // Input-side decode of the request currently presented on the bus.
    always_comb begin
        w_accept_ok = reset && ((r_state == S_IDLE) || (r_state == S_RESP));
        w_in_range  = f_in_range(memory_addr);
        w_in_idx    = f_idx(memory_addr);
        w_in_rd_ok  = f_is_read(memory_instr, memory_wstrb) && w_in_range;
        w_wr_en     = w_accept_ok && memory_valid && !memory_instr &&
                      (memory_wstrb != 4'b0000) && w_in_range;
    end

`ifdef MEMORY_LATENCY_EN
    // The final WAIT edge reads using the request captured at acceptance.
    always_comb begin
        w_q_rd_ok = f_is_read(r_instr, r_wstrb) && f_in_range(r_addr);
        w_rd_idx  = (r_state == S_WAIT) ? f_idx(r_addr) : w_in_idx;
    end
`else
    // Without wait states, the read always happens at the acceptance edge.
    always_comb begin
        w_rd_idx = w_in_idx;
    end
`endif

    assign w_mem_rd = r_mem[w_rd_idx];

    // The parameter only matters when wait states are compiled in.
    assign w_unused = ^{4'(LATENCY)};

    // Array write: byte-masked commit at the acceptance edge. Contents are not reset.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (memory_wstrb[i]) begin
                    r_mem[w_in_idx][8*i +: 8] <= memory_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request FSM. Ready and rdata are registered and are non-zero only in RESP.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_rdata <= '0;
`ifdef MEMORY_LATENCY_EN
            r_cnt   <= '0;
            r_addr  <= '0;
            r_instr <= 1'b0;
            r_wstrb <= '0;
`endif
        end else begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (memory_valid) begin
`ifdef MEMORY_LATENCY_EN
                        r_addr  <= memory_addr;
                        r_instr <= memory_instr;
                        r_wstrb <= memory_wstrb;
                        if (LATENCY == 0) begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                            r_rdata <= w_in_rd_ok ? w_mem_rd : 32'h0;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= LAT_M1;
                        end
`else
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        r_rdata <= w_in_rd_ok ? w_mem_rd : 32'h0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
`ifdef MEMORY_LATENCY_EN
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        r_rdata <= w_q_rd_ok ? w_mem_rd : 32'h0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign memory_ready = r_ready;
    assign memory_rdata = r_rdata;
    assign o_state      = r_state;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed bench for memory_responder with a scoreboard.
// The driver pushes the expected rdata and the expected ready cycle for each
// request it issues. A monitor pops one entry on each ready pulse and compares
// both values. It also checks that rdata is 0 whenever ready is low.
module tb_memory_responder;
  localparam int          DEPTH = 16384;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef MEMORY_LATENCY_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        memory_valid = 1'b0;
  logic        memory_instr = 1'b0;
  logic [31:0] memory_addr = '0;
  logic [31:0] memory_wdata = '0;
  logic [3:0]  memory_wstrb = '0;
  logic [31:0] memory_rdata;
  logic        memory_ready;
  logic [1:0]  o_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] m_exp;
  int          m_exp_cyc;
  logic [31:0] pat [8];

  memory_responder #(
    .DEPTH  (DEPTH),
    .BASE   (BASE),
    .LATENCY(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .memory_valid(memory_valid),
    .memory_instr(memory_instr),
    .memory_addr (memory_addr),
    .memory_wdata(memory_wdata),
    .memory_wstrb(memory_wstrb),
    .memory_rdata(memory_rdata),
    .memory_ready(memory_ready),
    .o_state     (o_state)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required finish");
    $fatal(1, "watchdog");
  end

  // monitor: compares DUT outputs at the falling edge
  always @(negedge clock) begin
    if (memory_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: ready at cycle %0d, required no ready", cyc);
      end else begin
        m_exp     = exp_q.pop_front();
        m_exp_cyc = exp_cyc_q.pop_front();
        total++;
        if (memory_rdata !== m_exp) begin
          bad++;
          $display("FAIL rdata: got %08h, required %08h (cycle %0d)", memory_rdata, m_exp, cyc);
        end
        total++;
        if (cyc != m_exp_cyc) begin
          bad++;
          $display("FAIL ready_cycle: got %0d, required %0d", cyc, m_exp_cyc);
        end
      end
    end else begin
      total++;
      if (memory_rdata !== 32'h0) begin
        bad++;
        $display("FAIL idle_rdata: got %08h, required 00000000 (cycle %0d)", memory_rdata, cyc);
      end
    end
  end

  // driver: present a request, record its expectation at the acceptance edge,
  // then wait for ready. Valid is left high so the caller can chain requests.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic ins,
                        input logic [31:0] exp_rd);
    logic got;
    memory_valid = 1'b1;
    memory_addr  = a;
    memory_wdata = wd;
    memory_wstrb = st;
    memory_instr = ins;
    @(posedge clock);
    #1;
    exp_q.push_back(exp_rd);
    exp_cyc_q.push_back(cyc + LAT);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (memory_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: no ready for addr %08h, required ready", a);
    end
  endtask

  task automatic idle(input int n);
    memory_valid = 1'b0;
    memory_wstrb = 4'b0000;
    memory_instr = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    pat = '{32'h01234567, 32'h89ABCDEF, 32'h13579BDF, 32'h2468ACE0,
            32'hF0E1D2C3, 32'hB4A59687, 32'h78695A4B, 32'h3C2D1E0F};

    // Reset held with a write presented: no ready, no commit.
    memory_valid = 1'b1;
    memory_addr  = 32'h20;
    memory_wdata = 32'hCAFEF00D;
    memory_wstrb = 4'hF;
    repeat (4) @(negedge clock);
    total++;
    if (o_state !== 2'd0 || memory_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: state=%0d ready=%0b, required state=0 ready=0", o_state, memory_ready);
    end
    reset = 1'b1;
    do_req(32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
    idle(1);

    // Preload words 0..7 back-to-back, then read them back-to-back.
    for (int i = 0; i < 8; i++) do_req(32'(i * 4), pat[i], 4'hF, 1'b0, 32'h0);
    idle(1);
    for (int i = 0; i < 8; i++) do_req(32'(i * 4), 32'h0, 4'h0, i[0], pat[i]);
    idle(1);

    // A fetch with strobes set is a read and leaves the array unchanged.
    do_req(32'h0, 32'hFFFFFFFF, 4'hF, 1'b1, pat[0]);
    idle(1);
    do_req(32'h0, 32'h0, 4'h0, 1'b0, pat[0]);
    idle(2);

    // Byte-masked write.
    do_req(32'h10, 32'h11223344, 4'hF, 1'b0, 32'h0);
    idle(1);
    do_req(32'h10, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0);
    idle(1);
    do_req(32'h10, 32'h0, 4'h0, 1'b0, 32'h11BB33DD);
    idle(1);

    // Out of range: the write is dropped and the read returns 0.
    do_req(32'h0001_0000, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    idle(1);
    do_req(32'h0001_0000, 32'h0, 4'h0, 1'b0, 32'h0);
    idle(1);
    do_req(32'h0, 32'h0, 4'h0, 1'b0, pat[0]);
    do_req(32'h3, 32'h0, 4'h0, 1'b0, pat[0]);
    idle(1);
    do_req(32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0, 32'h0);
    idle(1);

    // Last in-range word.
    do_req(32'h0000_FFFC, 32'h5A5A5A5A, 4'hF, 1'b0, 32'h0);
    do_req(32'h0000_FFFC, 32'h0, 4'h0, 1'b0, 32'h5A5A5A5A);
    idle(1);

    // Back-to-back: fetch word 0, then a data read of word 1.
    do_req(32'h0, 32'h0, 4'h0, 1'b1, pat[0]);
    do_req(32'h4, 32'h0, 4'h0, 1'b0, pat[1]);
    idle(1);

    // Reset abort: no ready; the next request completes normally.
    memory_valid = 1'b1;
    memory_addr  = 32'h8;
    memory_wstrb = 4'h0;
    memory_instr = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (memory_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_ready: got %0b, required 0", memory_ready);
    end
    reset = 1'b1;
    do_req(32'h8, 32'h0, 4'h0, 1'b0, pat[2]);
    idle(1);

    // The write presented during reset was committed only after release.
    do_req(32'h20, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);
    idle(3);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d expectations pending, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
